// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter on the MEM-stage store bus.
// Byte stores to DATA_ADDR are queued in a small FIFO and sent as 8N1 frames on tx.
module mmio_uart_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] DATA_ADDR    = 8'hFF,
  parameter logic [7:0] STAT_ADDR    = 8'hFE
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DIN,
  input  logic        wren,
  input  logic [2:0]  func3,
  output logic [31:0] DOUT,
  output logic        tx,
  output logic        tx_busy
);

  localparam int         PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  COUNT_FULL = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txStateT;

  txStateT          state;
  logic [15:0]      baudCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       shiftReg;
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [3:0]       count;
  logic             overrun;

  logic pushReq;
  logic pushOk;
  logic popNow;
  logic bitDone;
  logic full;
  logic empty;

  // Only the low byte is ever sent, so the store width and upper data bits are unused.
  logic unusedBits;
  assign unusedBits = ^{func3, DIN[31:8]};

  always_comb begin
    full    = (count == COUNT_FULL);
    empty   = (count == 4'd0);
    bitDone = (baudCnt == BAUD_LAST);
    popNow  = !empty && ((state == IDLE) || ((state == STOP) && bitDone));
    pushReq = wren && (ADDR == DATA_ADDR);
    pushOk  = pushReq && (!full || popNow);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= 4'd0;
      overrun <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
      if (popNow) rdPtr <= rdPtr + PTR_W'(1);
      case ({pushOk, popNow})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (pushReq && !pushOk) overrun <= 1'b1;
      else if (wren && (ADDR == STAT_ADDR)) overrun <= 1'b0;
    end
  end

  // When full and popping, wrPtr equals rdPtr; the pop reads the old entry before the overwrite.
  always_ff @(posedge clock) begin
    if (pushOk) fifoMem[wrPtr] <= DIN[7:0];
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      baudCnt  <= 16'd0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          baudCnt <= 16'd0;
          if (popNow) begin
            shiftReg <= fifoMem[rdPtr];
            state    <= START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (bitDone) begin
            baudCnt <= 16'd0;
            bitIdx  <= 3'd0;
            state   <= DATA;
            tx      <= shiftReg[0];
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        DATA: begin
          if (bitDone) begin
            baudCnt <= 16'd0;
            if (bitIdx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              shiftReg <= shiftReg >> 1;
              tx       <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        STOP: begin
          if (bitDone) begin
            baudCnt <= 16'd0;
            // Chain straight into the next start bit when more bytes are waiting.
            if (popNow) begin
              shiftReg <= fifoMem[rdPtr];
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state   <= IDLE;
              tx_busy <= 1'b0;
            end
          end else begin
            baudCnt <= baudCnt + 16'd1;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          baudCnt <= 16'd0;
        end
      endcase
    end
  end

  always_comb begin
    DOUT = 32'd0;
    if (ADDR == STAT_ADDR) DOUT = {24'd0, count, overrun, empty, full, tx_busy};
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped console transmitter: the responder on the core's data-memory store interface.
- Sits beside the data RAM on the MEM-stage bus and shares its address, write-data, write-enable and func3 signals.
- Byte stores to the data address are queued in a FIFO and serialised as 8N1 UART frames on `tx`.
- Replaces the simulation-only "character at MEM[255]" console with a synthesisable output.

Parameters:
- CLKS_PER_BIT, 434 — clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 8 — byte FIFO entries; power of two, 2..8.
- DATA_ADDR, 8'hFF — store address that enqueues a byte.
- STAT_ADDR, 8'hFE — status register address.

Ports:
- clock  in  1  — system clock, rising edge.
- clear  in  1  — asynchronous reset, active-high.
- ADDR  in  8  — byte address, equal to the MEM-stage ALU result [7:0].
- DIN  in  32  — store data.
- wren  in  1  — store strobe, one cycle per store.
- func3  in  3  — store width (sb/sh/sw); ignored for the data path.
- DOUT  out  32  — read data, combinational from ADDR.
- tx  out  1  — serial output, idles high.
- tx_busy  out  1  — high when the FSM is not in IDLE.

Behaviour:
- Reset, asynchronous on clear=1:
  - tx=1, tx_busy=0, FSM=IDLE.
  - FIFO pointers and count = 0; overrun = 0; bit and baud counters = 0.
  - A frame in progress is abandoned immediately and not resumed.
- Push:
  - Condition: wren=1 and ADDR==DATA_ADDR.
  - DIN[7:0] is enqueued whatever func3 is (sb, sh and sw all send the low byte).
- Full FIFO: the push is dropped and sticky overrun is set.
  - Exception: a pop happens in the same cycle. The pop frees a slot first, the push is accepted, and count is unchanged.
- Clearing overrun: wren=1 and ADDR==STAT_ADDR clears overrun; DIN is ignored.
- Stores to any other address are ignored.
- Status read (ADDR==STAT_ADDR): DOUT = {24'b0, count[3:0], overrun, empty, full, tx_busy}.
- Any other ADDR reads 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when count!=0 (registered), pop the head into an 8-bit shift register and go to START. tx drives 0 from the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit, LSB first. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - STOP exit: if count!=0 in STOP's last cycle, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency: a push sampled at edge k into an empty FIFO with FSM=IDLE makes tx fall at edge k+1.
- Empty and push simultaneously: the pop decision uses the registered count, so there is no bypass and the rule above applies.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- Pointers: wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).
- Registered outputs: tx and tx_busy come directly from registers (glitch-free).

Test Plan:
- Single byte (CLKS_PER_BIT=4): sb 0x55 to 0xFF at edge k.
  - tx=0 for edges k+1..k+4.
  - Bits 1,0,1,0,1,0,1,0, four cycles each.
  - tx=1 for four cycles; tx_busy low at edge k+41.
- Back-to-back: stores 'H' (0x48) and 'i' (0x69) on consecutive cycles → 80 contiguous frame cycles, no idle between stop and start, and empty=1 afterwards.
- Width handling: sw 0x12345641 and sh 0xBEEF to 0xFF → frames carry 0x41 then 0xEF.
- Overflow (depth 8): 10 stores on consecutive cycles → 9 accepted (1 in the shifter, 8 queued).
  - Reading 0xFE gives DOUT=0x0000008B.
  - Storing to 0xFE then gives 0x83.
  - Only 9 frames are emitted.
- Reset mid-frame: assert clear during DATA bit 3 → tx=1 and tx_busy=0 asynchronously; status reads 0x04; no frame resumes after release.
- Other addresses: a store to 0x10 does not change the FIFO; a read of 0xFF or 0x10 returns 0.
